// File: rtl/btn_uart_msg_tx.sv
// Debounced multi-button front end: one character per press (plus optional auto-repeat),
// round-robin arbitrated onto the uart tx_start/din handshake with one byte in flight.

module btn_uart_msg_lane #(
    parameter int DB_CYCLES  = 3750000,
    parameter int RPT_EN     = 1,
    parameter int RPT_DELAY  = 62500000,
    parameter int RPT_PERIOD = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db,
    output logic ev
);
    localparam int DBW = $clog2(DB_CYCLES + 1);

    logic           s1, s2, db_q, rise;
    logic [DBW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= db;
            // any agreement with the current level restarts the stability count
            if (s2 == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
                db     <= ~db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    assign rise = db & ~db_q;

    generate
        if (RPT_EN != 0) begin : g_rpt
            localparam int RW = $clog2(RPT_DELAY + 1);
            logic [RW-1:0] rpt_cnt;
            logic          fire;

            assign fire = db && (rpt_cnt == RW'(RPT_DELAY));
            assign ev   = rise | fire;

            // after a fire, reload so the next one lands RPT_PERIOD cycles later
            always_ff @(posedge clk) begin
                if (rst || !db)
                    rpt_cnt <= '0;
                else if (fire)
                    rpt_cnt <= RW'(RPT_DELAY - RPT_PERIOD + 1);
                else
                    rpt_cnt <= rpt_cnt + RW'(1);
            end
        end else begin : g_norpt
            assign ev = rise;
        end
    endgenerate
endmodule

module btn_uart_msg_tx #(
    parameter int N_BTN      = 4,
    parameter int DBIT       = 8,
    parameter int CHAR_BASE  = 'h41,
    parameter int DB_CYCLES  = 3750000,
    parameter int RPT_EN     = 1,
    parameter int RPT_DELAY  = 62500000,
    parameter int RPT_PERIOD = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic             tx_done_tick,
    output logic             tx_start,
    output logic [DBIT-1:0]  tx_data,
    output logic [N_BTN-1:0] btn_db,
    output logic             busy,
    output logic [7:0]       drop_cnt
);
    localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                    state, state_n;
    logic [N_BTN-1:0]          ev, pending, clr, merge;
    logic [N_BTN-1:0][PW-1:0]  rot_idx;
    logic [PW-1:0]             rr_ptr, grant_idx;
    logic                      grant_vld, start_n, busy_n;
    logic [3:0]                n_merge;
    logic [8:0]                drop_sum;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_uart_msg_lane #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_EN    (RPT_EN),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .btn(btn[i]),
            .db (btn_db[i]),
            .ev (ev[i])
        );
        assign rot_idx[i] = PW'((int'(rr_ptr) + i) % N_BTN);
    end

    // scan from the far end so the first hit at/after rr_ptr wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (pending[rot_idx[k]]) begin
                grant_vld = 1'b1;
                grant_idx = rot_idx[k];
            end
        end
    end

    always_comb begin
        state_n = state;
        start_n = 1'b0;
        busy_n  = busy;
        clr     = '0;
        case (state)
            S_IDLE: if (grant_vld) begin
                start_n        = 1'b1;
                busy_n         = 1'b1;
                clr[grant_idx] = 1'b1;
                state_n        = S_WAIT;
            end
            S_WAIT: if (tx_done_tick) begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        merge   = ev & pending & ~clr;
        n_merge = '0;
        for (int i = 0; i < N_BTN; i++)
            if (merge[i]) n_merge = n_merge + 4'd1;
        drop_sum = {1'b0, drop_cnt} + 9'(n_merge);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            pending  <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            tx_start <= start_n;
            busy     <= busy_n;
            pending  <= (pending & ~clr) | ev;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (start_n) begin
                tx_data <= DBIT'(CHAR_BASE + int'(grant_idx));
                rr_ptr  <= (grant_idx == PW'(N_BTN - 1)) ? '0 : grant_idx + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_btn_uart_msg_tx.sv
// Directed bench for btn_uart_msg_tx: a time-based behavioural model checked every cycle,
// plus literal expectations for press latency, send order, repeats, merges and reset.

module tb_btn_uart_msg_tx;
    localparam int N = 4, DB = 4, RD = 40, RP = 10;

    logic       clk = 1'b0, rst = 1'b1, tx_done_tick = 1'b0;
    logic [3:0] btn = '0;
    logic       tx_start, busy;
    logic [7:0] tx_data, drop_cnt;
    logic [3:0] btn_db;

    btn_uart_msg_tx #(
        .N_BTN(N), .DBIT(8), .CHAR_BASE('h41), .DB_CYCLES(DB),
        .RPT_EN(1), .RPT_DELAY(RD), .RPT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .tx_done_tick(tx_done_tick),
        .tx_start(tx_start), .tx_data(tx_data), .btn_db(btn_db),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0;
    // model: hist[d] = btn sampled d edges ago
    logic [3:0] hist[$];
    logic [3:0] m_db = '0, m_pend = '0;
    logic       m_busy = 1'b0, m_start = 1'b0;
    logic [7:0] m_data = '0, m_drop = '0;
    int         m_rr = 0;
    int         m_rise[4];
    // stub and logs
    int         stub_delay = 20, tick_due = -1;
    logic       force_tick = 1'b0;
    logic [7:0] sent[$];
    int         start_cyc[$];
    int         db_rise_cyc[4];
    logic [3:0] db_prev = '0;
    int         c0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [3:0] ev, clr, merge;
        int age, j, s;
        bit all_diff;
        if (rst) begin
            hist.delete();
            for (int d = 0; d < DB + 2; d++) hist.push_front(4'b0);
            m_db = '0; m_pend = '0; m_busy = 0; m_start = 0; m_data = '0;
            m_drop = '0; m_rr = 0; tick_due = -1;
            return;
        end
        hist.push_front(btn);
        if (hist.size() > DB + 2) void'(hist.pop_back());
        ev = '0;
        for (int i = 0; i < N; i++) if (m_db[i]) begin
            age = cyc - m_rise[i] - 1;
            if (age == 0 || (age >= RD && (age - RD) % RP == 0)) ev[i] = 1'b1;
        end
        clr = '0; m_start = 0;
        if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--) begin
                j = (m_rr + k) % N;
                if (m_pend[j]) clr = 4'b1 << j;
            end
            if (clr != 0) begin
                for (int i = 0; i < N; i++) if (clr[i]) j = i;
                m_start = 1; m_data = 8'h41 + 8'(j); m_rr = (j + 1) % N; m_busy = 1;
            end
        end else if (tx_done_tick) m_busy = 0;
        merge = ev & m_pend & ~clr;
        s = int'(m_drop) + $countones(merge);
        m_drop = (s > 255) ? 8'hFF : 8'(s);
        m_pend = (m_pend & ~clr) | ev;
        // level flips once the last DB synchronised samples all disagree with it
        for (int i = 0; i < N; i++) begin
            all_diff = 1;
            for (int d = 2; d <= DB + 1; d++) if (hist[d][i] == m_db[i]) all_diff = 0;
            if (all_diff) begin
                m_db[i] = ~m_db[i];
                if (m_db[i]) m_rise[i] = cyc;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("btn_db", 32'(btn_db), 32'(m_db));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (tx_start) begin sent.push_back(tx_data); start_cyc.push_back(cyc - c0); end
        for (int i = 0; i < N; i++) if (btn_db[i] && !db_prev[i]) db_rise_cyc[i] = cyc - c0;
        db_prev = btn_db;
        if (m_start) tick_due = cyc + stub_delay;
        tx_done_tick = (cyc + 1 == tick_due) || force_tick;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic begin_test();
        sent.delete(); start_cyc.delete(); c0 = cyc;
        for (int i = 0; i < N; i++) db_rise_cyc[i] = -1;
    endtask

    task automatic press(input logic [3:0] m, input int len);
        btn = m; run(len); btn = '0;
    endtask

    initial begin
        rst = 1; run(3); rst = 0; run(2);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_drop", 32'(drop_cnt), 0);
        chk("reset_db", 32'(btn_db), 0);

        // clean press of btn[0]
        begin_test(); press(4'b0001, 30); run(40);
        chk("t1_db_edge", 32'(db_rise_cyc[0]), 6);
        chk("t1_nsent", 32'(sent.size()), 1);
        if (sent.size() == 1) begin
            chk("t1_start_edge", 32'(start_cyc[0]), 8);
            chk("t1_data", 32'(sent[0]), 32'h41);
        end

        // short glitch on btn[2]
        begin_test(); press(4'b0100, 3); run(20);
        chk("t2_nsent", 32'(sent.size()), 0);
        chk("t2_db", 32'(btn_db), 0);
        chk("t2_drop", 32'(drop_cnt), 0);

        // move rr_ptr to 2, then btn[1]+btn[3] together
        begin_test(); press(4'b0010, 10); run(40);
        chk("t3_pre", 32'(sent.size() == 1 ? sent[0] : 8'h00), 32'h42);
        begin_test(); press(4'b1010, 10); run(60);
        chk("t3_nsent", 32'(sent.size()), 2);
        if (sent.size() == 2) begin
            chk("t3_first", 32'(sent[0]), 32'h44);
            chk("t3_second", 32'(sent[1]), 32'h42);
        end

        // auto-repeat with a fast uart
        stub_delay = 5;
        begin_test(); press(4'b0001, 80); run(60);
        chk("t4_nsent", 32'(sent.size()), 5);
        if (sent.size() == 5) begin
            chk("t4_s0", 32'(start_cyc[0]), 8);
            chk("t4_s1", 32'(start_cyc[1]), 48);
            chk("t4_s2", 32'(start_cyc[2]), 58);
            chk("t4_s3", 32'(start_cyc[3]), 68);
            chk("t4_s4", 32'(start_cyc[4]), 78);
            chk("t4_data", 32'(sent[4]), 32'h41);
        end
        chk("t4_drop", 32'(drop_cnt), 0);

        // slow uart: repeats merge into the pending request
        stub_delay = 200;
        begin_test(); press(4'b0001, 100); run(120);
        chk("t5_drop", 32'(drop_cnt), 5);
        chk("t5_nsent", 32'(sent.size()), 2);
        if (sent.size() == 2) chk("t5_second_edge", 32'(start_cyc[1]), 209);
        chk("t5_busy", 32'(busy), 1);

        // reset while waiting, then a stray tick
        rst = 1; run(2); rst = 0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_data", 32'(tx_data), 0);
        chk("t6_drop", 32'(drop_cnt), 0);
        begin_test();
        force_tick = 1; step(); force_tick = 0; run(5);
        chk("t6_late_tick", 32'(sent.size()), 0);
        stub_delay = 20;
        begin_test(); press(4'b0100, 10); run(40);
        chk("t6_nsent", 32'(sent.size()), 1);
        if (sent.size() == 1) chk("t6_data_after", 32'(sent[0]), 32'h43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
